// File: rtl/mc_control.sv
// Multicycle MIPS32 main control FSM with a parameterised memory-wait stall.
// Optional addi support is compiled in when the ADDI_EN macro is defined.
//
// state   | meaning
// FETCH   | read instruction at PC, IR load and PC+4 on final wait cycle
// DECODE  | register read, branch target into ALUOut, opcode dispatch
// MEMADR  | effective address rs + imm for lw/sw
// MEMRD   | data memory read at ALUOut
// MEMWB   | write MDR into rt
// MEMWR   | data memory write at ALUOut
// EXEC    | R-type ALU operation
// RWB     | write ALUOut into rd
// BRANCH  | beq compare, conditional PC load from ALUOut
// JUMP    | PC load from jump target
// ADDI_EX | rs + imm for addi
// ADDI_WB | write ALUOut into rt
module mc_control #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [2:0] AluOp,
    output logic [1:0] PCSource,
    output logic       Illegal,
    output logic [3:0] State
);
    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_state;
    logic       wait_done;
    logic       op_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign wait_done = (cnt_q == WAIT_MAX);

    always_comb begin
        op_legal = 1'b1;
        case (Opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef ADDI_EN
            OP_ADDI:                              op_legal = 1'b1;
`endif
            default:                              op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        cnt_d   = '0;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = ADDI_EX;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            EXEC:    state_d = RWB;
`ifdef ADDI_EN
            ADDI_EX: state_d = ADDI_WB;
`endif
            default: state_d = FETCH;
        endcase
        // Memory states stall here; the counter only runs while holding.
        if (mem_state && !wait_done) begin
            state_d = state_q;
            cnt_d   = cnt_q + 4'd1;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        AluSrcA     = 1'b0;
        AluSrcB     = 2'b00;
        AluOp       = 3'b000;
        PCSource    = 2'b00;
        Illegal     = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                AluSrcB = 2'b01;
                IRWrite = wait_done;
                PCWrite = wait_done;
            end
            DECODE: begin
                AluSrcB = 2'b11;
                Illegal = !op_legal;
            end
            MEMADR: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                AluSrcA = 1'b1;
                AluOp   = 3'b010;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                AluSrcA     = 1'b1;
                AluOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`ifdef ADDI_EN
            ADDI_EX: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
            end
            ADDI_WB: begin
                RegWrite = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign State = state_q;
endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: MEM_WAIT = 0 and MEM_WAIT = 2 instances.
// Expected output vectors are queued per cycle and popped by a negedge monitor.
module tb_mc_control;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Opcode = 6'b000000;
    logic       sel = 1'b0;

    always #5 clk = ~clk;

    logic       a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_srca, a_ill;
    logic [1:0] a_srcb, a_pcsrc;
    logic [2:0] a_aluop;
    logic [3:0] a_state;
    logic       b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_srca, b_ill;
    logic [1:0] b_srcb, b_pcsrc;
    logic [2:0] b_aluop;
    logic [3:0] b_state;

    mc_control #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .Opcode(Opcode),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mrd),
        .MemWrite(a_mwr), .IRWrite(a_irw), .MemtoReg(a_m2r), .RegDst(a_rdst),
        .RegWrite(a_rw), .AluSrcA(a_srca), .AluSrcB(a_srcb), .AluOp(a_aluop),
        .PCSource(a_pcsrc), .Illegal(a_ill), .State(a_state)
    );

    mc_control #(.MEM_WAIT(2)) dut2 (
        .clk(clk), .rst(rst), .Opcode(Opcode),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mrd),
        .MemWrite(b_mwr), .IRWrite(b_irw), .MemtoReg(b_m2r), .RegDst(b_rdst),
        .RegWrite(b_rw), .AluSrcA(b_srca), .AluSrcB(b_srcb), .AluOp(b_aluop),
        .PCSource(b_pcsrc), .Illegal(b_ill), .State(b_state)
    );

    // Vector order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
    // RegDst RegWrite AluSrcA AluSrcB AluOp PCSource Illegal State
    logic [21:0] vec0, vec2;
    assign vec0 = {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw,
                   a_srca, a_srcb, a_aluop, a_pcsrc, a_ill, a_state};
    assign vec2 = {b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw,
                   b_srca, b_srcb, b_aluop, b_pcsrc, b_ill, b_state};

    int checks = 0;
    int errors = 0;
    logic [21:0] exp_q[$];
    string       tag_q[$];

    function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic last, input logic ill);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, srca = 0;
        logic [1:0] srcb = 2'b00, pcsrc = 2'b00;
        logic [2:0] aluop = 3'b000;
        case (st)
            4'd0:  begin mrd = 1; srcb = 2'b01; irw = last; pcw = last; end
            4'd1:  begin srcb = 2'b11; end
            4'd2:  begin srca = 1; srcb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin srca = 1; aluop = 3'b010; end
            4'd7:  begin rw = 1; rdst = 1; end
            4'd8:  begin srca = 1; aluop = 3'b001; pcwc = 1; pcsrc = 2'b01; end
            4'd9:  begin pcw = 1; pcsrc = 2'b10; end
            4'd10: begin srca = 1; srcb = 2'b10; end
            4'd11: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, ill, st};
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b (state act=%0d req=%0d)",
                     name, act, exp, act[3:0], exp[3:0]);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [21:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, sel ? vec2 : vec0, e);
        end
    end

    // Called at posedge+1 while the DUT sits in its first FETCH cycle.
    task automatic run_instr(input string name, input logic [5:0] op, input int n,
                             input logic [0:4][3:0] seq, input logic ill, input int w);
        int idx = 0;
        Opcode = op;
        for (int i = 0; i < n; i++) begin
            logic [3:0] st;
            int reps;
            st = seq[i];
            reps = (st == 4'd0 || st == 4'd3 || st == 4'd5) ? w + 1 : 1;
            for (int r = 0; r < reps; r++) begin
                exp_q.push_back(exp_vec(st, r == reps - 1, ill && st == 4'd1));
                tag_q.push_back($sformatf("%s[%0d]", name, idx));
                idx++;
            end
        end
        for (int k = 0; k < 64 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain actual=%0d_left required=0_left", name, exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit found;
        #1;
        check("reset_w0", vec0, exp_vec(4'd0, 1'b1, 1'b0));
        check("reset_w2", vec2, exp_vec(4'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        sel = 1'b0;
        run_instr("rtype", 6'b000000, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 1'b0, 0);
        run_instr("lw",    6'b100011, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 1'b0, 0);
        run_instr("sw",    6'b101011, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}, 1'b0, 0);
        run_instr("beq",   6'b000100, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0}, 1'b0, 0);
        run_instr("j",     6'b000010, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 1'b0, 0);
        run_instr("ill",   6'b111111, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0}, 1'b1, 0);
`ifdef ADDI_EN
        run_instr("addi",  6'b001000, 4, {4'd0, 4'd1, 4'd10, 4'd11, 4'd0}, 1'b0, 0);
`else
        run_instr("addi",  6'b001000, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0}, 1'b1, 0);
`endif
        run_instr("rtype2", 6'b000000, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 1'b0, 0);
        run_instr("tail0", 6'b000000, 1, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, 0);

        sel = 1'b1;
        do_reset();
        run_instr("w2_lw",    6'b100011, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 1'b0, 2);
        run_instr("w2_sw",    6'b101011, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}, 1'b0, 2);
        run_instr("w2_rtype", 6'b000000, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 1'b0, 2);
        run_instr("w2_beq",   6'b000100, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0}, 1'b0, 2);
        run_instr("w2_tail",  6'b000000, 1, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, 2);

        sel = 1'b0;
        do_reset();
        Opcode = 6'b000000;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (a_state == 4'd6) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL reach_exec actual=state%0d required=state6", a_state);
        end else begin
            check("pre_rst_exec", vec0, exp_vec(4'd6, 1'b0, 1'b0));
            #3;
            rst = 1'b1;
            #1;
            check("async_rst_w0", vec0, exp_vec(4'd0, 1'b1, 1'b0));
            check("async_rst_w2", vec2, exp_vec(4'd0, 1'b0, 1'b0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
